ccip_c0_rd_req_throttle: RTL and testbench

//  Buffers AFU memory-read request headers (t_ccip_c0_ReqMemHdr) in a FIFO and issues them on CCI-P Tx channel 0.

---
 rtl/ccip_c0_rd_req_throttle.sv | 161 ++++++++++++++++
 tb/tb_ccip_c0_rd_req_throttle.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c0_rd_req_throttle.sv
// CCI-P c0 read-request throttle: queues AFU read headers and issues them on c0 Tx
// while the FIU has room and the in-flight read-line count stays within MAX_LINES.
module ccip_c0_rd_req_throttle #(
  parameter int DEPTH     = 16,
  parameter int MAX_LINES = 256
) (
  input  logic                           pClk,
  input  logic                           reset_n,
  input  logic                           afu_req_valid,
  input  logic [73:0]                    afu_req_hdr,
  output logic                           afu_req_ready,
  input  logic                           c0TxAlmFull,
  input  logic                           c0Rx_rspValid,
  input  logic [3:0]                     c0Rx_resp_type,
  output logic [74:0]                    c0Tx,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic [$clog2(MAX_LINES+1)-1:0] lines_outstanding,
  output logic                           err_sticky
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(MAX_LINES + 1);
  localparam int SW = LW + 2;

  localparam logic [1:0] CL_LEN_1   = 2'b00;
  localparam logic [1:0] CL_LEN_2   = 2'b01;
  localparam logic [1:0] CL_LEN_4   = 2'b11;
  localparam logic [1:0] CL_LEN_BAD = 2'b10;
  localparam logic [3:0] RSP_RDLINE = 4'h0;

  // Encoding 2'b10 is undefined; it is charged as a single line.
  function automatic logic [2:0] line_len(input logic [1:0] cl);
    logic [2:0] len;
    case (cl)
      CL_LEN_1: len = 3'd1;
      CL_LEN_2: len = 3'd2;
      CL_LEN_4: len = 3'd4;
      default:  len = 3'd1;
    endcase
    return len;
  endfunction

  logic [73:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lines_q, lines_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          iss_vld_q, iss_vld_d;
  logic [73:0]   iss_hdr_q, iss_hdr_d;
  logic [74:0]   tx_q, tx_d;

  logic [73:0]   head_s;
  logic [2:0]    head_len_s;
  logic [SW-1:0] lines_sum_s;
  logic          push_s, issue_s, retire_s;

  // Head-of-queue evaluation and the per-cycle handshake decisions.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    head_len_s  = line_len(head_s[69:68]);
    lines_sum_s = SW'(lines_q) + SW'(head_len_s);
    push_s      = afu_req_valid & ready_q;
    retire_s    = c0Rx_rspValid && (c0Rx_resp_type == RSP_RDLINE);
    issue_s     = (cnt_q != {CW{1'b0}}) && !c0TxAlmFull && (lines_sum_s <= SW'(MAX_LINES));
  end

  // Next-state for pointers, occupancy, line accounting and the issue pipeline.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    err_d     = err_q;
    iss_vld_d = issue_s;
    iss_hdr_d = iss_hdr_q;
    tx_d      = {tx_q[74:1], 1'b0};

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue_s) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      iss_hdr_d = head_s;
      lines_d   = lines_q + LW'(head_len_s);
    end else begin
      rd_ptr_d  = rd_ptr_q;
      iss_hdr_d = iss_hdr_q;
      lines_d   = lines_q;
    end

    // A retire against an empty count is a protocol error and must not wrap.
    if (retire_s && (lines_q != {LW{1'b0}})) begin
      lines_d = lines_d - LW'(1);
    end else begin
      lines_d = lines_d;
    end

    case ({push_s, issue_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q
          | (issue_s && (head_s[69:68] == CL_LEN_BAD))
          | (retire_s && (lines_q == {LW{1'b0}}));

    if (iss_vld_q) begin
      tx_d = {iss_hdr_q, 1'b1};
    end else begin
      tx_d = {tx_q[74:1], 1'b0};
    end
  end

  assign ready_d = (cnt_d < CW'(DEPTH));

  // Control and output registers.
  always_ff @(posedge pClk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      lines_q   <= {LW{1'b0}};
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_hdr_q <= 74'd0;
      tx_q      <= 75'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      iss_vld_q <= iss_vld_d;
      iss_hdr_q <= iss_hdr_d;
      tx_q      <= tx_d;
    end
  end

  // Header storage has no reset; an entry is only read after it has been counted in.
  always_ff @(posedge pClk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= afu_req_hdr;
    end
  end

  assign afu_req_ready     = ready_q;
  assign c0Tx              = tx_q;
  assign fifo_count        = cnt_q;
  assign lines_outstanding = lines_q;
  assign err_sticky        = err_q;

endmodule

// File: tb/tb_ccip_c0_rd_req_throttle.sv
// Self-checking bench for ccip_c0_rd_req_throttle: a 256-line instance for most
// scenarios and an 8-line instance for the line-cap stall sequence.
module tb_ccip_c0_rd_req_throttle;

  logic        pClk = 1'b0;
  logic        reset_n;
  logic        afu_req_valid;
  logic [73:0] afu_req_hdr;
  logic        c0TxAlmFull;
  logic        c0Rx_rspValid;
  logic [3:0]  c0Rx_resp_type;

  logic        rdy, rdy8;
  logic [74:0] tx, tx8;
  logic [4:0]  cnt, cnt8;
  logic [8:0]  lines;
  logic [3:0]  lines8;
  logic        err, err8;

  always #5 pClk = ~pClk;

  ccip_c0_rd_req_throttle #(.DEPTH(16), .MAX_LINES(256)) dut (
    .pClk(pClk), .reset_n(reset_n),
    .afu_req_valid(afu_req_valid), .afu_req_hdr(afu_req_hdr), .afu_req_ready(rdy),
    .c0TxAlmFull(c0TxAlmFull), .c0Rx_rspValid(c0Rx_rspValid), .c0Rx_resp_type(c0Rx_resp_type),
    .c0Tx(tx), .fifo_count(cnt), .lines_outstanding(lines), .err_sticky(err)
  );

  ccip_c0_rd_req_throttle #(.DEPTH(16), .MAX_LINES(8)) dut8 (
    .pClk(pClk), .reset_n(reset_n),
    .afu_req_valid(afu_req_valid), .afu_req_hdr(afu_req_hdr), .afu_req_ready(rdy8),
    .c0TxAlmFull(c0TxAlmFull), .c0Rx_rspValid(c0Rx_rspValid), .c0Rx_resp_type(c0Rx_resp_type),
    .c0Tx(tx8), .fifo_count(cnt8), .lines_outstanding(lines8), .err_sticky(err8)
  );

  typedef struct {
    logic [1:0] cl_len;
    int         exp_lines;
    int         exp_err;
  } len_vec_t;

  typedef struct {
    logic       rsp_valid;
    logic [3:0] rsp_type;
    int         exp_lines;
  } rsp_vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          sel8 = 1'b0;
  logic [73:0] exp_q[$];
  int          n_iss = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkh(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One cycle: sample c0Tx on the falling edge against the scoreboard, then step past the rising edge.
  task automatic tick();
    logic [74:0] t;
    @(negedge pClk);
    t = sel8 ? tx8 : tx;
    if (reset_n && t[0]) begin
      if (n_iss == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_iss++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual=%h required=none", t[74:1]);
      end else begin
        chkh("issued_hdr", t[74:1], exp_q.pop_front());
      end
    end
    @(posedge pClk);
    #1;
    cyc++;
  endtask

  function automatic logic [73:0] mk(input logic [1:0] cl);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    r[69:68] = cl;
    return r[73:0];
  endfunction

  task automatic push(input logic [73:0] h);
    int n;
    n = 0;
    afu_req_valid = 1'b1;
    afu_req_hdr   = h;
    while (!(sel8 ? rdy8 : rdy) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_ready required=ready");
    end else begin
      exp_q.push_back(h);
    end
    tick();
    afu_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    afu_req_valid  = 1'b0;
    c0TxAlmFull    = 1'b0;
    c0Rx_rspValid  = 1'b0;
    c0Rx_resp_type = 4'h0;
    reset_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    n_iss = 0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic respond(input logic [3:0] ty);
    c0Rx_rspValid  = 1'b1;
    c0Rx_resp_type = ty;
    tick();
    c0Rx_rspValid  = 1'b0;
  endtask

  len_vec_t len_tbl[4];
  rsp_vec_t rsp_tbl[4];

  initial begin
    int acc;
    int e1;
    logic [73:0] h;

    len_tbl[0] = '{2'b00, 1, 0};
    len_tbl[1] = '{2'b01, 2, 0};
    len_tbl[2] = '{2'b11, 4, 0};
    len_tbl[3] = '{2'b10, 1, 1};
    rsp_tbl[0] = '{1'b1, 4'h4, 6};
    rsp_tbl[1] = '{1'b1, 4'h1, 6};
    rsp_tbl[2] = '{1'b0, 4'h0, 6};
    rsp_tbl[3] = '{1'b1, 4'h0, 5};

    reset_n = 1'b1;
    afu_req_valid = 1'b0; afu_req_hdr = 74'd0;
    c0TxAlmFull = 1'b0; c0Rx_rspValid = 1'b0; c0Rx_resp_type = 4'h0;
    #2 reset_n = 1'b0;
    @(posedge pClk);
    #1;
    chkh("rst_c0Tx_hdr", tx[74:1], 74'd0);
    chki("rst_c0Tx_valid", int'(tx[0]), 0);
    chki("rst_fifo_count", int'(cnt), 0);
    chki("rst_lines", int'(lines), 0);
    chki("rst_err", int'(err), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chki("ready_after_release", int'(rdy), 1);

    // Three single-line requests: order, exact headers, two-cycle latency.
    push(mk(2'b00));
    e1 = cyc;
    push(mk(2'b00));
    push(mk(2'b00));
    repeat (5) tick();
    chki("t1_issue_count", n_iss, 3);
    chki("t1_first_latency", first_cyc - e1, 2);
    chki("t1_consecutive", last_cyc - first_cyc, 2);
    chki("t1_lines", int'(lines), 3);
    chki("t1_scb_drained", exp_q.size(), 0);

    // Fill past capacity under almost-full, then drain back-to-back.
    do_reset();
    c0TxAlmFull = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      h = mk(2'b00);
      afu_req_valid = 1'b1;
      afu_req_hdr   = h;
      if (rdy) begin
        exp_q.push_back(h);
        acc++;
      end
      tick();
    end
    afu_req_valid = 1'b0;
    chki("t2_accepts", acc, 16);
    chki("t2_fifo_full", int'(cnt), 16);
    chki("t2_ready_low", int'(rdy), 0);
    chki("t2_no_issue", n_iss, 0);
    c0TxAlmFull = 1'b0;
    repeat (20) tick();
    chki("t2_issue_count", n_iss, 16);
    chki("t2_back_to_back", last_cyc - first_cyc, 15);
    chki("t2_lines", int'(lines), 16);
    chki("t2_fifo_empty", int'(cnt), 0);

    // Almost-full asserted mid-stream stops pops in the same cycle.
    do_reset();
    c0TxAlmFull = 1'b1;
    for (int i = 0; i < 8; i++) push(mk(2'b00));
    c0TxAlmFull = 1'b0;
    repeat (3) tick();
    c0TxAlmFull = 1'b1;
    repeat (6) tick();
    chki("t3_issued_after_almfull", n_iss, 3);
    chki("t3_fifo_left", int'(cnt), 5);
    c0TxAlmFull = 1'b0;
    repeat (10) tick();
    chki("t3_resume_count", n_iss, 8);
    chki("t3_lines", int'(lines), 8);

    // Line cap of 8: LEN_4, LEN_4, LEN_2 with responses freeing room.
    do_reset();
    sel8 = 1'b1;
    push(mk(2'b11));
    push(mk(2'b11));
    push(mk(2'b01));
    repeat (6) tick();
    chki("t4_lines_cap", int'(lines8), 8);
    chki("t4_third_waits", int'(cnt8), 1);
    chki("t4_issued_two", n_iss, 2);
    respond(4'h0);
    chki("t4_lines_7", int'(lines8), 7);
    tick();
    chki("t4_still_stalled", int'(cnt8), 1);
    respond(4'h0);
    chki("t4_lines_6", int'(lines8), 6);
    tick();
    chki("t4_lines_8", int'(lines8), 8);
    chki("t4_third_popped", int'(cnt8), 0);
    repeat (3) tick();
    chki("t4_issued_three", n_iss, 3);
    sel8 = 1'b0;

    // Issue LEN_2 and retire one line in the same cycle from 5 outstanding.
    do_reset();
    push(mk(2'b11));
    push(mk(2'b00));
    repeat (4) tick();
    chki("t5_lines_5", int'(lines), 5);
    push(mk(2'b01));
    respond(4'h0);
    chki("t5_issue_and_retire", int'(lines), 6);
    foreach (rsp_tbl[i]) begin
      c0Rx_rspValid  = rsp_tbl[i].rsp_valid;
      c0Rx_resp_type = rsp_tbl[i].rsp_type;
      tick();
      c0Rx_rspValid  = 1'b0;
      chki($sformatf("t5_rsp_vec%0d", i), int'(lines), rsp_tbl[i].exp_lines);
    end
    repeat (2) tick();
    chki("t5_scb_drained", exp_q.size(), 0);
    chki("t5_no_err", int'(err), 0);

    // Retire with nothing outstanding.
    do_reset();
    respond(4'h0);
    chki("t6_lines_stay_0", int'(lines), 0);
    chki("t6_err_set", int'(err), 1);
    repeat (3) tick();
    chki("t6_err_sticky", int'(err), 1);
    do_reset();
    chki("t6_err_cleared_by_reset", int'(err), 0);

    // Line-length decode table, including the illegal encoding.
    foreach (len_tbl[i]) begin
      do_reset();
      push(mk(len_tbl[i].cl_len));
      repeat (4) tick();
      chki($sformatf("t7_len_lines%0d", i), int'(lines), len_tbl[i].exp_lines);
      chki($sformatf("t7_len_err%0d", i), int'(err), len_tbl[i].exp_err);
      chki($sformatf("t7_len_issued%0d", i), n_iss, 1);
    end

    // Reset asserted mid-burst with five still queued.
    do_reset();
    c0TxAlmFull = 1'b1;
    for (int i = 0; i < 7; i++) push(mk(2'b00));
    c0TxAlmFull = 1'b0;
    tick();
    tick();
    chki("t8_queued_5", int'(cnt), 5);
    chki("t8_valid_before_reset", int'(tx[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    chki("t8_async_valid_low", int'(tx[0]), 0);
    chkh("t8_async_hdr_clear", tx[74:1], 74'd0);
    chki("t8_async_fifo_clear", int'(cnt), 0);
    chki("t8_async_lines_clear", int'(lines), 0);
    exp_q.delete();
    n_iss = 0;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chki("t8_no_stale_issue", n_iss, 0);
    chki("t8_fifo_stays_empty", int'(cnt), 0);
    chki("t8_lines_stay_0", int'(lines), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
